// File: rtl/cv32e41p_pkg.sv
// Shared types for the APU write-back buffer: entry payload and bus widths.
package cv32e41p_pkg;

  localparam int unsigned APU_WB_ADDR_W  = 6;
  localparam int unsigned APU_WB_DATA_W  = 32;
  localparam int unsigned APU_WB_FLAGS_W = 5;
  localparam int unsigned APU_WB_NSRC    = 3;

  typedef struct packed {
    logic [APU_WB_ADDR_W-1:0]  waddr;
    logic [APU_WB_DATA_W-1:0]  result;
    logic [APU_WB_FLAGS_W-1:0] flags;
  } apu_wb_entry_t;

endpackage

// File: rtl/cv32e41p_apu_wb_buffer_if.sv
// APU result / regfile port B / decoder hazard bundle around the write-back buffer.
interface cv32e41p_apu_wb_buffer_if
  import cv32e41p_pkg::*;
#(
  parameter int unsigned DATA_W  = APU_WB_DATA_W,
  parameter int unsigned FLAGS_W = APU_WB_FLAGS_W,
  parameter int unsigned ADDR_W  = APU_WB_ADDR_W
);

  logic                                  apu_rvalid_i;
  logic [DATA_W-1:0]                     apu_result_i;
  logic [FLAGS_W-1:0]                    apu_flags_i;
  logic [ADDR_W-1:0]                     apu_waddr_i;
  logic                                  wb_port_busy_i;
  logic                                  is_decoding_i;
  logic [APU_WB_NSRC-1:0][ADDR_W-1:0]    read_regs_i;
  logic [APU_WB_NSRC-1:0]                read_regs_valid_i;

  logic                                  regfile_we_o;
  logic [ADDR_W-1:0]                     regfile_waddr_o;
  logic [DATA_W-1:0]                     regfile_wdata_o;
  logic                                  fflags_we_o;
  logic [FLAGS_W-1:0]                    fflags_o;
  logic                                  stall_o;
  logic                                  read_dep_o;
  logic                                  empty_o;
  logic                                  overflow_o;

  modport slave (
    input  apu_rvalid_i, apu_result_i, apu_flags_i, apu_waddr_i, wb_port_busy_i,
           is_decoding_i, read_regs_i, read_regs_valid_i,
    output regfile_we_o, regfile_waddr_o, regfile_wdata_o, fflags_we_o, fflags_o,
           stall_o, read_dep_o, empty_o, overflow_o
  );

  modport master (
    output apu_rvalid_i, apu_result_i, apu_flags_i, apu_waddr_i, wb_port_busy_i,
           is_decoding_i, read_regs_i, read_regs_valid_i,
    input  regfile_we_o, regfile_waddr_o, regfile_wdata_o, fflags_we_o, fflags_o,
           stall_o, read_dep_o, empty_o, overflow_o
  );

endinterface

// File: rtl/cv32e41p_apu_wb_fifo.sv
// In-order circular FIFO of write-back entries; exposes every slot and its
// occupancy so the owner can scan queued destinations for hazards.
module cv32e41p_apu_wb_fifo
  import cv32e41p_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  apu_wb_entry_t            push_data_i,
  input  logic                     pop_i,
  output apu_wb_entry_t            head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output apu_wb_entry_t            entries_o [DEPTH],
  output logic [DEPTH-1:0]         valid_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  apu_wb_entry_t    mem_q [DEPTH];
  apu_wb_entry_t    mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Caller guarantees no pop when empty and no push when full without a pop.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (push_i) begin
      mem_d[wr_ptr_q] = push_data_i;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_i) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // A slot is occupied when its distance from the read pointer is below the count.
  always_comb begin
    valid_o = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      valid_o[i] = {1'b0, PTR_W'(i) - rd_ptr_q} < count_q;
    end
  end

  assign head_o    = mem_q[rd_ptr_q];
  assign count_o   = count_q;
  assign entries_o = mem_q;

endmodule

// File: rtl/cv32e41p_apu_wb_buffer.sv
// Commits APU results to regfile port B, bypassing when idle and queueing in
// order while the port is claimed; drives issue stall and decoder RAW hazard.
module cv32e41p_apu_wb_buffer
  import cv32e41p_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  cv32e41p_apu_wb_buffer_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [CNT_W-1:0] count;
  apu_wb_entry_t    in_entry;
  apu_wb_entry_t    head;
  apu_wb_entry_t    entries [DEPTH];
  logic [DEPTH-1:0] valid;

  logic empty_c, full_c, bypass_c, pop_c, push_c, drop_c, read_dep_c;
  logic overflow_q, overflow_d;

  // Bypass only when empty so a fresh result never overtakes a queued one.
  always_comb begin
    in_entry.waddr  = bus.apu_waddr_i;
    in_entry.result = bus.apu_result_i;
    in_entry.flags  = bus.apu_flags_i;
    empty_c    = (count == '0);
    full_c     = (count == CNT_W'(DEPTH));
    bypass_c   = empty_c & bus.apu_rvalid_i & ~bus.wb_port_busy_i;
    pop_c      = ~empty_c & ~bus.wb_port_busy_i;
    drop_c     = bus.apu_rvalid_i & ~bypass_c & full_c & ~pop_c;
    push_c     = bus.apu_rvalid_i & ~bypass_c & ~drop_c;
    overflow_d = overflow_q | drop_c;
  end

  cv32e41p_apu_wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (push_c),
    .push_data_i (in_entry),
    .pop_i       (pop_c),
    .head_o      (head),
    .count_o     (count),
    .entries_o   (entries),
    .valid_o     (valid)
  );

  always_comb begin
    bus.regfile_we_o    = 1'b0;
    bus.regfile_waddr_o = '0;
    bus.regfile_wdata_o = '0;
    bus.fflags_we_o     = 1'b0;
    bus.fflags_o        = '0;
    if (bypass_c) begin
      bus.regfile_we_o    = 1'b1;
      bus.regfile_waddr_o = in_entry.waddr;
      bus.regfile_wdata_o = in_entry.result;
      bus.fflags_we_o     = 1'b1;
      bus.fflags_o        = in_entry.flags;
    end else if (pop_c) begin
      bus.regfile_we_o    = 1'b1;
      bus.regfile_waddr_o = head.waddr;
      bus.regfile_wdata_o = head.result;
      bus.fflags_we_o     = 1'b1;
      bus.fflags_o        = head.flags;
    end
  end

  // Head being popped this cycle still hazards; the bypassed input never does.
  always_comb begin
    read_dep_c = 1'b0;
    for (int unsigned e = 0; e < DEPTH; e++) begin
      for (int unsigned i = 0; i < APU_WB_NSRC; i++) begin
        if (valid[e] && bus.read_regs_valid_i[i] &&
            (bus.read_regs_i[i] == entries[e].waddr)) begin
          read_dep_c = 1'b1;
        end
      end
    end
    read_dep_c = read_dep_c & bus.is_decoding_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

  assign bus.stall_o    = (count >= CNT_W'(DEPTH - 1));
  assign bus.read_dep_o = read_dep_c;
  assign bus.empty_o    = empty_c;
  assign bus.overflow_o = overflow_q;

`ifdef CV32E41P_ASSERT_ON
  a_no_drop: assert property (@(posedge clk_i) disable iff (!rst_ni) !drop_c);
`endif

endmodule

// File: tb/tb_cv32e41p_apu_wb_buffer.sv
// Directed and random checks of the APU write-back buffer against a queue model.
module tb_cv32e41p_apu_wb_buffer;

  localparam int unsigned DEPTH = 2;

  typedef struct {
    logic [5:0]  a;
    logic [31:0] d;
    logic [4:0]  f;
  } ent_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;
  ent_t q[$];
  logic ovf_m = 1'b0;

  always #5 clk = ~clk;

  cv32e41p_apu_wb_buffer_if bus ();

  cv32e41p_apu_wb_buffer #(.DEPTH(DEPTH)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic drive(input logic rv, input logic [5:0] a, input logic [31:0] d,
                       input logic [4:0] f, input logic busy, input logic dec,
                       input logic [17:0] regs, input logic [2:0] rvld);
    bus.apu_rvalid_i      = rv;
    bus.apu_waddr_i       = a;
    bus.apu_result_i      = d;
    bus.apu_flags_i       = f;
    bus.wb_port_busy_i    = busy;
    bus.is_decoding_i     = dec;
    bus.read_regs_i       = regs;
    bus.read_regs_valid_i = rvld;
  endtask

  // Expected outputs derived from the queue contents and current inputs.
  task automatic check_outputs();
    logic        we;
    logic [5:0]  ea;
    logic [31:0] ed;
    logic [4:0]  ef;
    logic        dep;
    logic [5:0]  rr;
    we = 1'b0; ea = '0; ed = '0; ef = '0; dep = 1'b0;
    if (!bus.wb_port_busy_i) begin
      if (q.size() == 0 && bus.apu_rvalid_i) begin
        we = 1'b1; ea = bus.apu_waddr_i; ed = bus.apu_result_i; ef = bus.apu_flags_i;
      end else if (q.size() > 0) begin
        we = 1'b1; ea = q[0].a; ed = q[0].d; ef = q[0].f;
      end
    end
    if (bus.is_decoding_i) begin
      foreach (q[e]) begin
        for (int i = 0; i < 3; i++) begin
          rr = bus.read_regs_i[i];
          if (bus.read_regs_valid_i[i] && rr == q[e].a) dep = 1'b1;
        end
      end
    end
    check("we",       64'(bus.regfile_we_o),    64'(we));
    check("waddr",    64'(bus.regfile_waddr_o), 64'(ea));
    check("wdata",    64'(bus.regfile_wdata_o), 64'(ed));
    check("fflags_we",64'(bus.fflags_we_o),     64'(we));
    check("fflags",   64'(bus.fflags_o),        64'(ef));
    check("stall",    64'(bus.stall_o),         64'(q.size() >= int'(DEPTH) - 1));
    check("read_dep", 64'(bus.read_dep_o),      64'(dep));
    check("empty",    64'(bus.empty_o),         64'(q.size() == 0));
    check("overflow", 64'(bus.overflow_o),      64'(ovf_m));
  endtask

  // Advance the model by one clock using the currently driven inputs.
  task automatic tick();
    int   n;
    logic popped;
    logic byp;
    ent_t e;
    ent_t dropped;
    n      = q.size();
    popped = 1'b0;
    byp    = (n == 0) && bus.apu_rvalid_i && !bus.wb_port_busy_i;
    if (!bus.wb_port_busy_i && n > 0) begin
      dropped = q.pop_front();
      popped  = 1'b1;
    end
    if (bus.apu_rvalid_i && !byp) begin
      e.a = bus.apu_waddr_i; e.d = bus.apu_result_i; e.f = bus.apu_flags_i;
      if (n < int'(DEPTH) || popped) q.push_back(e);
      else ovf_m = 1'b1;
    end
    @(posedge clk);
  endtask

  task automatic cyc(input logic rv, input logic [5:0] a, input logic [31:0] d,
                     input logic busy);
    @(negedge clk);
    drive(rv, a, d, 5'(a), busy, 1'b0, '0, 3'b000);
    #1;
    check_outputs();
    tick();
  endtask

  function automatic logic [5:0] rand_addr();
    logic [5:0] a;
    a = 6'($urandom_range(0, 3));
    if ($urandom_range(0, 1) == 1) a[5] = 1'b1;
    return a;
  endfunction

  initial begin
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0, '0, 3'b000);
    #2;
    check_outputs();
    check("rst_empty", 64'(bus.empty_o), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);

    // Bypass on an empty buffer
    @(negedge clk);
    drive(1'b1, 6'h05, 32'hDEADBEEF, 5'h1, 1'b0, 1'b0, '0, 3'b000);
    #1;
    check_outputs();
    check("byp_we",    64'(bus.regfile_we_o),    64'd1);
    check("byp_waddr", 64'(bus.regfile_waddr_o), 64'h05);
    check("byp_wdata", 64'(bus.regfile_wdata_o), 64'hDEADBEEF);
    check("byp_empty", 64'(bus.empty_o),         64'd1);
    tick();

    // Queue two while busy, then drain in order
    cyc(1'b1, 6'h21, 32'h1111_0021, 1'b1);
    cyc(1'b1, 6'h22, 32'h1111_0022, 1'b1);
    @(negedge clk);
    drive(1'b0, '0, '0, '0, 1'b1, 1'b0, '0, 3'b000);
    #1;
    check_outputs();
    check("q_stall", 64'(bus.stall_o),      64'd1);
    check("q_we",    64'(bus.regfile_we_o), 64'd0);
    tick();
    @(negedge clk);
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0, '0, 3'b000);
    #1;
    check_outputs();
    check("drain1", 64'(bus.regfile_waddr_o), 64'h21);
    tick();
    @(negedge clk);
    #1;
    check_outputs();
    check("drain2", 64'(bus.regfile_waddr_o), 64'h22);
    tick();
    @(negedge clk);
    #1;
    check("drain_empty", 64'(bus.empty_o), 64'd1);

    // Simultaneous pop and push
    cyc(1'b1, 6'h03, 32'h0000_0003, 1'b1);
    @(negedge clk);
    drive(1'b1, 6'h04, 32'h0000_0004, 5'h4, 1'b0, 1'b0, '0, 3'b000);
    #1;
    check_outputs();
    check("sim_waddr", 64'(bus.regfile_waddr_o), 64'h03);
    tick();
    @(negedge clk);
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0, '0, 3'b000);
    #1;
    check_outputs();
    check("sim_empty", 64'(bus.empty_o),         64'd0);
    check("sim_next",  64'(bus.regfile_waddr_o), 64'h04);
    tick();

    // RAW hazard on a queued destination
    cyc(1'b1, 6'h0A, 32'h0000_000A, 1'b1);
    @(negedge clk);
    drive(1'b0, '0, '0, '0, 1'b1, 1'b1, {6'h00, 6'h0A, 6'h00}, 3'b010);
    #1;
    check_outputs();
    check("dep_hit", 64'(bus.read_dep_o), 64'd1);
    tick();
    @(negedge clk);
    drive(1'b0, '0, '0, '0, 1'b1, 1'b0, {6'h00, 6'h0A, 6'h00}, 3'b010);
    #1;
    check_outputs();
    check("dep_nodec", 64'(bus.read_dep_o), 64'd0);
    tick();
    cyc(1'b0, '0, '0, 1'b0);

    // Overflow: third result while full and busy is dropped
    cyc(1'b1, 6'h11, 32'hAAAA_0011, 1'b1);
    cyc(1'b1, 6'h12, 32'hAAAA_0012, 1'b1);
    cyc(1'b1, 6'h13, 32'hAAAA_0013, 1'b1);
    @(negedge clk);
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0, '0, 3'b000);
    #1;
    check_outputs();
    check("ovf_set",   64'(bus.overflow_o),      64'd1);
    check("ovf_head",  64'(bus.regfile_wdata_o), 64'hAAAA_0011);
    tick();
    @(negedge clk);
    #1;
    check_outputs();
    check("ovf_second", 64'(bus.regfile_wdata_o), 64'hAAAA_0012);
    tick();
    @(negedge clk);
    #1;
    check("ovf_sticky", 64'(bus.overflow_o), 64'd1);
    check("ovf_empty",  64'(bus.empty_o),    64'd1);

    // Reset while two entries are queued
    cyc(1'b1, 6'h31, 32'hBBBB_0031, 1'b1);
    cyc(1'b1, 6'h32, 32'hBBBB_0032, 1'b1);
    @(negedge clk);
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0, '0, 3'b000);
    rst_n = 1'b0;
    #1;
    q.delete();
    ovf_m = 1'b0;
    check("rst_we",    64'(bus.regfile_we_o), 64'd0);
    check("rst_mid_e", 64'(bus.empty_o),      64'd1);
    check("rst_stall", 64'(bus.stall_o),      64'd0);
    check_outputs();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      drive(1'($urandom_range(0, 99) < 45), rand_addr(), $urandom(), 5'($urandom()),
            1'($urandom_range(0, 99) < 50), 1'($urandom_range(0, 1)),
            {rand_addr(), rand_addr(), rand_addr()}, 3'($urandom()));
      #1;
      check_outputs();
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
